// File: rtl/mux_scan_nto1_if.sv
// Channel bus, selection controls and registered output stream of the N-to-1 scan mux.
// master drives channel data, controls and ready; slave is the mux itself.
interface mux_scan_nto1_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4
);
  logic [NUM_CH*WIDTH-1:0] d;
  logic [SEL_W-1:0]        select;
  logic                    mode;
  logic [NUM_CH-1:0]       ch_en;
  logic [WIDTH-1:0]        out;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output d, select, mode, ch_en, out_ready,
    input  out, out_ch, out_valid
  );

  modport slave (
    input  d, select, mode, ch_en, out_ready,
    output out, out_ch, out_valid
  );
endinterface

// File: rtl/mux_scan_nto1.sv
// Registered N-to-1 channel mux with direct select or round-robin scan over an enable mask.
// Output is a valid/ready stream tagged with the source channel index.
module mux_scan_nto1 #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4
) (
  input logic             clk,
  input logic             rst,
  mux_scan_nto1_if.slave  bus_io
);

  if (SEL_W != $clog2(NUM_CH) || NUM_CH < 2 || (1 << SEL_W) != NUM_CH) begin : g_bad_params
    $error("mux_scan_nto1: NUM_CH must be a power of two >= 2 and SEL_W = log2(NUM_CH)");
  end

  logic [WIDTH-1:0]  out_q, out_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic [WIDTH-1:0]  ch_data [NUM_CH];
  logic [NUM_CH-1:0] rot_en;
  logic              scan_hit;
  logic [SEL_W-1:0]  scan_off;
  logic [SEL_W-1:0]  scan_idx;
  logic              load;

  // rot_en[i] is the enable of channel (ptr + i) mod NUM_CH; SEL_W-bit add wraps for free
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_data[gi] = bus_io.d[gi*WIDTH +: WIDTH];
    assign rot_en[gi]  = bus_io.ch_en[ptr_q + SEL_W'(gi)];
  end

  always_comb begin
    scan_hit = 1'b0;
    scan_off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot_en[i]) begin
        scan_hit = 1'b1;
        scan_off = SEL_W'(i);
      end
    end
  end

  assign scan_idx = ptr_q + scan_off;
  assign load     = !out_valid_q || bus_io.out_ready;

  always_comb begin
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (!bus_io.mode) begin
        out_d       = ch_data[bus_io.select];
        out_ch_d    = bus_io.select;
        out_valid_d = 1'b1;
      end else if (scan_hit) begin
        out_d       = ch_data[scan_idx];
        out_ch_d    = scan_idx;
        out_valid_d = 1'b1;
        ptr_d       = scan_idx + SEL_W'(1);
      end else begin
        // empty mask: drop valid but keep the last data/tag and pointer
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus_io.out       = out_q;
  assign bus_io.out_ch    = out_ch_q;
  assign bus_io.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Self-checking bench for mux_scan_nto1: directed plan scenarios plus randomized traffic vs a model.
module tb_mux_scan_nto1;
  localparam int WIDTH  = 8;
  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mux_scan_nto1_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus ();

  mux_scan_nto1 #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int         m_ptr;
  logic [7:0] m_out;
  int         m_ch;
  logic       m_valid;

  function automatic logic [7:0] chan(int k);
    return bus.d[k*WIDTH +: WIDTH];
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_out = '0; m_ch = 0; m_valid = 1'b0;
  endtask

  // apply the load rules to the model using current inputs, then advance one edge
  task automatic cycle();
    int k;
    bit found;
    if (!m_valid || bus.out_ready) begin
      if (!bus.mode) begin
        m_out = chan(int'(bus.select)); m_ch = int'(bus.select); m_valid = 1'b1;
      end else begin
        found = 0; k = 0;
        for (int j = 0; j < NUM_CH; j++)
          if (!found && bus.ch_en[(m_ptr + j) % NUM_CH]) begin
            found = 1; k = (m_ptr + j) % NUM_CH;
          end
        if (found) begin
          m_out = chan(k); m_ch = k; m_valid = 1'b1; m_ptr = (k + 1) % NUM_CH;
        end else m_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic set_ramp_data();
    for (int k = 0; k < NUM_CH; k++) bus.d[k*WIDTH +: WIDTH] = 8'(k * 8'h11);
  endtask

  task automatic async_reset_pulse(string tag);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out !== 8'h00 || bus.out_ch !== 4'd0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_async: out=%h ch=%0d v=%b required out=00 ch=0 v=0", tag, bus.out, bus.out_ch, bus.out_valid);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.mode = 1'b0; bus.select = 4'd7; bus.ch_en = '0; bus.out_ready = 1'b1;
    set_ramp_data();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cycle();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out !== 8'h77) begin
      n_fail++;
      $display("FAIL pre_reset_load: out=%h v=%b required out=77 v=1", bus.out, bus.out_valid);
    end
    async_reset_pulse("reset");
  endtask

  task automatic test_direct();
    bus.mode = 1'b0; bus.select = 4'd5; bus.out_ready = 1'b1;
    set_ramp_data();
    cycle();
    n_checks++;
    if (bus.out !== 8'h55 || bus.out_ch !== 4'd5 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL direct: out=%h ch=%0d v=%b required out=55 ch=5 v=1", bus.out, bus.out_ch, bus.out_valid);
    end
  endtask

  task automatic test_scan_wrap();
    int exp_ch [6] = '{0, 5, 10, 15, 0, 5};
    bus.mode = 1'b1; bus.ch_en = 16'h8421; bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_checks++;
      if (int'(bus.out_ch) != exp_ch[i] || bus.out !== 8'(exp_ch[i] * 8'h11) || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL scan_wrap[%0d]: ch=%0d out=%h v=%b required ch=%0d out=%h v=1",
                 i, bus.out_ch, bus.out, bus.out_valid, exp_ch[i], 8'(exp_ch[i] * 8'h11));
      end
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.d = {NUM_CH{8'hC3}};  // new data during a stall must not reach the held sample
      cycle();
      n_checks++;
      if (bus.out !== 8'h55 || bus.out_ch !== 4'd5 || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall[%0d]: out=%h ch=%0d v=%b required out=55 ch=5 v=1", i, bus.out, bus.out_ch, bus.out_valid);
      end
    end
    set_ramp_data();
    bus.out_ready = 1'b1;
    cycle();
    n_checks++;
    if (bus.out_ch !== 4'd10 || bus.out !== 8'hAA || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL after_stall: ch=%0d out=%h v=%b required ch=10 out=aa v=1", bus.out_ch, bus.out, bus.out_valid);
    end
  endtask

  task automatic test_empty_mask();
    bus.ch_en = '0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_mask[%0d]: v=%b required v=0", i, bus.out_valid);
      end
    end
    bus.ch_en = 16'h0008;
    cycle();
    n_checks++;
    if (bus.out_ch !== 4'd3 || bus.out !== 8'h33 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_single: ch=%0d out=%h v=%b required ch=3 out=33 v=1", bus.out_ch, bus.out, bus.out_valid);
    end
  endtask

  task automatic test_mode_switch();
    bus.ch_en = 16'h8421;
    cycle();  // ch 5
    cycle();  // ch 10, ptr 11
    n_checks++;
    if (bus.out_ch !== 4'd10) begin
      n_fail++;
      $display("FAIL reach_ch10: ch=%0d required 10", bus.out_ch);
    end
    bus.mode = 1'b0; bus.select = 4'd2;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if (bus.out_ch !== 4'd2 || bus.out !== 8'h22 || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL direct_sw[%0d]: ch=%0d out=%h required ch=2 out=22", i, bus.out_ch, bus.out);
      end
    end
    bus.mode = 1'b1; bus.ch_en = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if (int'(bus.out_ch) != 11 + i || bus.out !== 8'((11 + i) * 8'h11)) begin
        n_fail++;
        $display("FAIL resume_scan[%0d]: ch=%0d out=%h required ch=%0d", i, bus.out_ch, bus.out, 11 + i);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    bus.ch_en = 16'h8421;
    for (int i = 0; i < 8 && m_ch != 10; i++) cycle();
    n_checks++;
    if (bus.out_ch !== 4'd10) begin
      n_fail++;
      $display("FAIL mid_scan_reach: ch=%0d required 10", bus.out_ch);
    end
    async_reset_pulse("mid_scan");
    bus.ch_en = 16'hFFFF;
    cycle();
    n_checks++;
    if (bus.out_ch !== 4'd0 || bus.out !== 8'h00 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_scan: ch=%0d out=%h v=%b required ch=0 out=00 v=1", bus.out_ch, bus.out, bus.out_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NUM_CH; k++) bus.d[k*WIDTH +: WIDTH] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) bus.mode = 1'($urandom);
      bus.select = 4'($urandom);
      case ($urandom_range(0, 3))
        0: bus.ch_en = '0;
        1: bus.ch_en = 16'(1 << $urandom_range(0, 15));
        2: bus.ch_en = 16'($urandom) & 16'($urandom);
        default: bus.ch_en = 16'($urandom);
      endcase
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      n_checks++;
      if (bus.out_valid !== m_valid || int'(bus.out_ch) != m_ch || bus.out !== m_out) begin
        n_fail++;
        $display("FAIL random[%0d]: out=%h ch=%0d v=%b required out=%h ch=%0d v=%b",
                 n, bus.out, bus.out_ch, bus.out_valid, m_out, m_ch, m_valid);
      end
    end
  endtask

  initial begin
    bus.d = '0; bus.select = '0; bus.mode = 1'b0; bus.ch_en = '0; bus.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_direct();
    test_scan_wrap();
    test_backpressure();
    test_empty_mask();
    test_mode_switch();
    test_reset_mid_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
